// File: rtl/reg_file_ctrl.sv
// rtl/reg_file_ctrl.sv - initiator for a single-port register file: read, write, fetch-and-add, swap
module reg_file_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [1:0]        i_req_op,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_data,
   output logic              o_rf_rw,
   output logic [ADDR_W-1:0] o_rf_register,
   output logic [DATA_W-1:0] o_rf_data_in,
   input  logic [DATA_W-1:0] i_rf_data_out
);

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FADD  = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RSP  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_op;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_old;

   logic              w_accept;
   logic [1:0]        w_op;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_sum;

   logic              w_req_ready;
   logic              w_rsp_valid;
   logic [DATA_W-1:0] w_rsp_data;
   logic              w_rf_rw;
   logic [ADDR_W-1:0] w_rf_register;
   logic [DATA_W-1:0] w_rf_data_in;

   // Next state plus the registered-output values that belong to that next state.
   // Request fields are taken straight from the ports on the accept edge, otherwise
   // from the latched copies, so mid-op changes on the request bus are ignored.
   always_comb begin
      w_state_nxt   = r_state;
      w_accept      = i_req_valid && o_req_ready && (r_state == IDLE);
      w_op          = w_accept ? i_req_op    : r_op;
      w_addr        = w_accept ? i_req_addr  : r_addr;
      w_wdata       = w_accept ? i_req_wdata : r_wdata;
      w_old         = (r_state == CAP) ? i_rf_data_out : r_old;
      w_sum         = w_old + w_wdata;
      w_req_ready   = 1'b0;
      w_rsp_valid   = 1'b0;
      w_rsp_data    = '0;
      w_rf_rw       = 1'b0;
      w_rf_register = '0;
      w_rf_data_in  = '0;

      case (r_state)
         IDLE: if (w_accept) w_state_nxt = (i_req_op == OP_WRITE) ? WR : RD;
         RD:   w_state_nxt = CAP;
         CAP:  w_state_nxt = (r_op == OP_READ) ? RSP : WR;
         WR:   w_state_nxt = RSP;
         RSP:  if (i_rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      case (w_state_nxt)
         IDLE: w_req_ready = 1'b1;
         RD:   w_rf_register = w_addr;
         WR: begin
            w_rf_rw       = 1'b1;
            w_rf_register = w_addr;
            w_rf_data_in  = (w_op == OP_FADD) ? w_sum : w_wdata;
         end
         RSP: begin
            w_rsp_valid = 1'b1;
            if (r_state == RSP)
               w_rsp_data = o_rsp_data;
            else if (w_op == OP_WRITE)
               w_rsp_data = '0;
            else
               w_rsp_data = w_old;
         end
         default: w_req_ready = 1'b0;
      endcase
   end

   // State, request latches, captured old value and all registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_op          <= '0;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_old         <= '0;
         o_req_ready   <= 1'b1;
         o_rsp_valid   <= 1'b0;
         o_rsp_data    <= '0;
         o_rf_rw       <= 1'b0;
         o_rf_register <= '0;
         o_rf_data_in  <= '0;
      end else begin
         r_state       <= w_state_nxt;
         o_req_ready   <= w_req_ready;
         o_rsp_valid   <= w_rsp_valid;
         o_rsp_data    <= w_rsp_data;
         o_rf_rw       <= w_rf_rw;
         o_rf_register <= w_rf_register;
         o_rf_data_in  <= w_rf_data_in;
         if (w_accept) begin
            r_op    <= i_req_op;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
         end
         if (r_state == CAP) r_old <= i_rf_data_out;
      end
   end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// tb/tb_reg_file_ctrl.sv - scoreboard bench for reg_file_ctrl with a behavioural register file
module tb_reg_file_ctrl;

   localparam logic [1:0] RD_OP = 2'b00;
   localparam logic [1:0] WR_OP = 2'b01;
   localparam logic [1:0] FA_OP = 2'b10;
   localparam logic [1:0] SW_OP = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [2:0] req_addr = 3'd0;
   logic [7:0] req_wdata = 8'd0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_data;
   logic       rf_rw;
   logic [2:0] rf_register;
   logic [7:0] rf_data_in;
   logic [7:0] rf_data_out = 8'd0;

   logic [7:0] mem [8];

   typedef struct {
      logic [7:0] data;
      int         lat;
      int         acc;
   } exp_t;
   exp_t q[$];

   int  n_vec = 0;
   int  n_fail = 0;
   int  cyc = 0;
   int  wr_cnt = 0;
   logic prev_valid = 1'b0;

   reg_file_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op(req_op), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
      .o_rf_rw(rf_rw), .o_rf_register(rf_register), .o_rf_data_in(rf_data_in),
      .i_rf_data_out(rf_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial for (int i = 0; i < 8; i++) mem[i] = 8'd0;

   always @(posedge clk) begin
      if (rf_rw && rf_register != 3'd0) mem[rf_register] <= rf_data_in;
      rf_data_out <= (rf_register == 3'd0) ? 8'd0 : mem[rf_register];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rf_rw) wr_cnt++;
      if (rsp_valid && !prev_valid) begin
         if (q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e.data));
            chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end
      prev_valid = rsp_valid;
   end

   task automatic issue(input logic [1:0] op, input logic [2:0] a, input logic [7:0] wd,
                        input logic [7:0] ex, input int lat, input bit push);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = a;
      req_wdata = wd;
      if (push) q.push_back('{ex, lat, cyc + 1});
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 2'($urandom_range(3));
      req_addr  = 3'($urandom_range(7));
      req_wdata = 8'($urandom_range(255));
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      while ((q.size() != 0 || !req_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_fail++;
         $display("FAIL drain: timed out with %0d pending, req_ready %0b, required 0 pending", q.size(), req_ready);
      end
   endtask

   initial begin
      int w0;
      int n;
      // reset, with a request presented that must be ignored
      req_valid = 1'b1;
      req_op    = WR_OP;
      req_addr  = 3'd6;
      req_wdata = 8'hEE;
      repeat (3) @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rf_rw", 32'(rf_rw), 32'd0);
      chk("rst_rf_register", 32'(rf_register), 32'd0);
      chk("rst_rf_data_in", 32'(rf_data_in), 32'd0);
      rst = 1'b0;

      // 1: write then read
      issue(WR_OP, 3'd3, 8'hA5, 8'h00, 1, 1'b1);
      issue(RD_OP, 3'd3, 8'h00, 8'hA5, 2, 1'b1);
      drain();

      // 2: index 0 reads zero and ignores writes
      issue(WR_OP, 3'd0, 8'h55, 8'h00, 1, 1'b1);
      issue(RD_OP, 3'd0, 8'h00, 8'h00, 2, 1'b1);
      issue(FA_OP, 3'd0, 8'h10, 8'h00, 3, 1'b1);
      issue(RD_OP, 3'd0, 8'h00, 8'h00, 2, 1'b1);
      drain();

      // 3: fetch-and-add wraps
      issue(WR_OP, 3'd5, 8'hFF, 8'h00, 1, 1'b1);
      issue(FA_OP, 3'd5, 8'h02, 8'hFF, 3, 1'b1);
      issue(RD_OP, 3'd5, 8'h00, 8'h01, 2, 1'b1);
      drain();

      // 4: swap with exactly one write cycle
      issue(WR_OP, 3'd2, 8'h12, 8'h00, 1, 1'b1);
      drain();
      w0 = wr_cnt;
      issue(SW_OP, 3'd2, 8'h34, 8'h12, 3, 1'b1);
      drain();
      chk("swap_write_cycles", 32'(wr_cnt - w0), 32'd1);
      issue(RD_OP, 3'd2, 8'h00, 8'h34, 2, 1'b1);
      drain();

      // 5: response back-pressure
      issue(WR_OP, 3'd4, 8'h3C, 8'h00, 1, 1'b1);
      drain();
      rsp_ready = 1'b0;
      issue(RD_OP, 3'd4, 8'h00, 8'h3C, 2, 1'b1);
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_data", 32'(rsp_data), 32'h3C);
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_rf_rw", 32'(rf_rw), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      drain();

      // 6: reset during CAP of a fetch-and-add drops it
      issue(WR_OP, 3'd1, 8'h07, 8'h00, 1, 1'b1);
      drain();
      w0 = wr_cnt;
      issue(FA_OP, 3'd1, 8'h01, 8'h00, 3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rf_rw", 32'(rf_rw), 32'd0);
      chk("midrst_rf_register", 32'(rf_register), 32'd0);
      repeat (4) @(negedge clk);
      chk("midrst_no_write", 32'(wr_cnt - w0), 32'd0);
      chk("midrst_r1", 32'(mem[1]), 32'h07);
      issue(RD_OP, 3'd1, 8'h00, 8'h07, 2, 1'b1);
      issue(FA_OP, 3'd6, 8'h05, 8'h00, 3, 1'b1);
      issue(SW_OP, 3'd6, 8'h09, 8'h05, 3, 1'b1);
      issue(RD_OP, 3'd6, 8'h00, 8'h09, 2, 1'b1);
      issue(WR_OP, 3'd7, 8'h81, 8'h00, 1, 1'b1);
      issue(FA_OP, 3'd7, 8'h80, 8'h81, 3, 1'b1);
      issue(RD_OP, 3'd7, 8'h00, 8'h01, 2, 1'b1);
      drain();
      repeat (5) @(negedge clk);
      chk("final_queue_empty", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
